// File: rtl/bp_cce_mmio_cfg_loader_mc.sv
// bp_cce_mmio_cfg_loader_mc: boot config master (clk_i/reset_i, ucode ROM port, io_cmd_* commands, io_resp_* responses, done/error status)
module bp_cce_mmio_cfg_loader_mc #(
   parameter int num_core_p = 2,
   parameter int core_id_width_p = 1,
   parameter int cfg_addr_width_p = 16,
   parameter int dword_width_p = 64,
   parameter int ucode_els_p = 256,
   parameter int ucode_width_p = 48,
   parameter int max_credits_p = 4,
   parameter logic [cfg_addr_width_p-1:0] ucode_base_p = 16'h8000,
   parameter logic [cfg_addr_width_p-1:0] reg_reset_p = 16'h0001,
   parameter logic [cfg_addr_width_p-1:0] reg_freeze_p = 16'h0002,
   parameter logic [cfg_addr_width_p-1:0] reg_cce_mode_p = 16'h0006,
   parameter logic [cfg_addr_width_p-1:0] reg_npc_p = 16'h0010,
   parameter logic [dword_width_p-1:0] cce_normal_p = 1,
   parameter logic [38:0] entry_pc_p = 39'h00_8000_0000,
   parameter logic [38:0] pc_stride_p = 39'h0,
   parameter bit verify_p = 1,
   parameter int sync_cycles_p = 256,
   parameter bit skip_ram_init_p = 0,
   localparam int idx_width_lp = (ucode_els_p > 1) ? $clog2(ucode_els_p) : 1
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   output logic [idx_width_lp-1:0]     ucode_addr_o,
   input  logic [ucode_width_p-1:0]    ucode_data_i,
   output logic                        io_cmd_v_o,
   output logic                        io_cmd_we_o,
   output logic [core_id_width_p-1:0]  io_cmd_core_o,
   output logic [cfg_addr_width_p-1:0] io_cmd_addr_o,
   output logic [dword_width_p-1:0]    io_cmd_data_o,
   input  logic                        io_cmd_yumi_i,
   input  logic                        io_resp_v_i,
   input  logic                        io_resp_we_i,
   input  logic [dword_width_p-1:0]    io_resp_data_i,
   output logic                        io_resp_ready_o,
   output logic                        done_o,
   output logic                        error_o,
   output logic [core_id_width_p-1:0]  err_core_o,
   output logic [idx_width_lp-1:0]     err_addr_o
);
   localparam logic [3:0] s_reset = 4'd0, s_reset_set = 4'd1, s_freeze_set = 4'd2, s_reset_clr = 4'd3,
                          s_send_ucode = 4'd4, s_verify = 4'd5, s_drain_v = 4'd6, s_cce_normal = 4'd7,
                          s_sync = 4'd8, s_send_pc = 4'd9, s_freeze_clr = 4'd10, s_drain = 4'd11,
                          s_done = 4'd12, s_err_halt = 4'd13;
   localparam int cred_w = $clog2(max_credits_p + 1);
   localparam int sync_w = (sync_cycles_p > 0) ? $clog2(sync_cycles_p + 1) : 1;
   localparam int ptr_w = (max_credits_p > 1) ? $clog2(max_credits_p) : 1;

   logic [3:0] state_r, state_n;
   logic [core_id_width_p-1:0] core_r;
   logic [idx_width_lp-1:0] idx_r;
   logic [sync_w-1:0] sync_r;
   logic [cred_w-1:0] cred_r, fcnt_r;
   logic [ptr_w-1:0] wptr_r, rptr_r;
   logic [core_id_width_p-1:0] fc_r [max_credits_p];
   logic [idx_width_lp-1:0] fi_r [max_credits_p];
   logic [ucode_width_p-1:0] fd_r [max_credits_p];
   logic per_core, loop, acc, resp_ok, push, pop, mismatch;
   logic last_core, last_idx, adv_core, phase_end, sync_done;
   logic [38:0] pc;
   logic unused_data;

   assign per_core = state_r inside {s_reset_set, s_freeze_set, s_reset_clr, s_cce_normal, s_send_pc, s_freeze_clr};
   assign loop = state_r inside {s_send_ucode, s_verify};
   assign io_cmd_v_o = (per_core | loop) & (cred_r < cred_w'(max_credits_p));
   assign acc = io_cmd_v_o & io_cmd_yumi_i;
   assign resp_ok = io_resp_v_i & (cred_r != '0);
   assign push = acc & (state_r == s_verify);
   assign pop = resp_ok & ~io_resp_we_i & (fcnt_r != '0);
   assign mismatch = pop & (io_resp_data_i[ucode_width_p-1:0] != fd_r[rptr_r]);
   assign last_core = core_r == core_id_width_p'(num_core_p - 1);
   assign last_idx = idx_r == idx_width_lp'(ucode_els_p - 1);
   assign adv_core = acc & (per_core | (loop & last_idx));
   assign phase_end = adv_core & last_core;
   assign sync_done = (state_r == s_sync) & (32'(sync_r) + 32'd1 >= 32'(sync_cycles_p));
   assign pc = entry_pc_p + 39'(core_r) * pc_stride_p;
   assign unused_data = &{1'b0, io_resp_data_i};

   assign ucode_addr_o = idx_r;
   assign io_resp_ready_o = 1'b1;
   assign done_o = state_r == s_done;
   assign io_cmd_we_o = state_r != s_verify;
   assign io_cmd_core_o = core_r;
   assign io_cmd_addr_o = (state_r == s_reset_set || state_r == s_reset_clr) ? reg_reset_p
                        : (state_r == s_freeze_set || state_r == s_freeze_clr) ? reg_freeze_p
                        : (state_r == s_cce_normal) ? reg_cce_mode_p
                        : (state_r == s_send_pc) ? reg_npc_p
                        : ucode_base_p + cfg_addr_width_p'(idx_r);
   assign io_cmd_data_o = (state_r == s_reset_set || state_r == s_freeze_set) ? dword_width_p'(1)
                        : (state_r == s_send_ucode) ? dword_width_p'(ucode_data_i)
                        : (state_r == s_cce_normal) ? cce_normal_p
                        : (state_r == s_send_pc) ? dword_width_p'(pc)
                        : '0;

   always_comb begin
      state_n = state_r;
      case (state_r)
         s_reset:      state_n = skip_ram_init_p ? s_freeze_clr : s_reset_set;
         s_reset_set:  state_n = phase_end ? s_freeze_set : state_r;
         s_freeze_set: state_n = phase_end ? s_reset_clr : state_r;
         s_reset_clr:  state_n = phase_end ? s_send_ucode : state_r;
         s_send_ucode: state_n = phase_end ? (verify_p ? s_verify : s_cce_normal) : state_r;
         s_verify:     state_n = phase_end ? s_drain_v : state_r;
         s_drain_v:    state_n = (cred_r == '0 && fcnt_r == '0) ? (error_o ? s_err_halt : s_cce_normal) : state_r;
         s_cce_normal: state_n = phase_end ? s_sync : state_r;
         s_sync:       state_n = sync_done ? s_send_pc : state_r;
         s_send_pc:    state_n = phase_end ? s_freeze_clr : state_r;
         s_freeze_clr: state_n = phase_end ? s_drain : state_r;
         s_drain:      state_n = (cred_r == '0) ? s_done : state_r;
         default:      state_n = state_r;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r <= s_reset;
         core_r <= '0;
         idx_r <= '0;
         sync_r <= '0;
         cred_r <= '0;
         fcnt_r <= '0;
         wptr_r <= '0;
         rptr_r <= '0;
         error_o <= 1'b0;
         err_core_o <= '0;
         err_addr_o <= '0;
      end else begin
         state_r <= state_n;
         cred_r <= cred_r + cred_w'(acc) - cred_w'(resp_ok);
         fcnt_r <= fcnt_r + cred_w'(push) - cred_w'(pop);
         sync_r <= (state_r == s_sync && !sync_done) ? sync_r + 1'b1 : '0;
         if (adv_core) core_r <= last_core ? '0 : core_r + 1'b1;
         if (acc & loop) idx_r <= last_idx ? '0 : idx_r + 1'b1;
         if (push) begin
            fc_r[wptr_r] <= core_r;
            fi_r[wptr_r] <= idx_r;
            fd_r[wptr_r] <= ucode_data_i;
            wptr_r <= (wptr_r == ptr_w'(max_credits_p - 1)) ? '0 : wptr_r + 1'b1;
         end
         if (pop) rptr_r <= (rptr_r == ptr_w'(max_credits_p - 1)) ? '0 : rptr_r + 1'b1;
         if (mismatch & ~error_o) begin
            error_o <= 1'b1;
            err_core_o <= fc_r[rptr_r];
            err_addr_o <= fi_r[rptr_r];
         end
      end
   end
endmodule

// File: tb/tb_bp_cce_mmio_cfg_loader_mc.sv
// tb_bp_cce_mmio_cfg_loader_mc: table-driven check of four loader configurations
module tb_bp_cce_mmio_cfg_loader_mc;
   typedef struct {
      logic we;
      logic [1:0] core;
      logic [15:0] addr;
      logic [63:0] data;
   } cmd_t;
   typedef struct {
      int inst;
      int pos;
      cmd_t exp;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] rst, v, we, yumi, rv, rwe, rrdy, done, err, yen;
   logic [3:0][1:0] uaddr, core, ecore, eaddr;
   logic [3:0][47:0] udata;
   logic [3:0][15:0] addr;
   logic [3:0][63:0] data, rdata;
   logic flip_en, corrupt, m_yumi, m_rv;
   logic p_v [4][3];
   logic p_we [4][3];
   logic [63:0] p_d [4][3];
   cmd_t lg [4][64];
   int lc [4][64];
   int n [4];
   int done_cyc [4];
   int cyc = 0;
   int n_chk = 0, n_fail = 0;
   vec_t vt [$];

   function automatic logic [47:0] rom(input logic [1:0] a);
      return 48'hA5C3_7E10_0000 + 48'(a) * 48'h0101_0011;
   endfunction

   function automatic cmd_t mk(input logic w, input int c, input logic [15:0] a, input logic [63:0] d);
      cmd_t r;
      r.we = w;
      r.core = 2'(c);
      r.addr = a;
      r.data = d;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   for (genvar g = 0; g < 4; g++) begin : u
      bp_cce_mmio_cfg_loader_mc #(
         .num_core_p(g == 1 ? 4 : 2), .core_id_width_p(2), .ucode_els_p(4),
         .max_credits_p(g == 3 ? 2 : 4), .pc_stride_p(g == 1 ? 39'h1000 : 39'h0),
         .verify_p(g == 0 || g == 3), .sync_cycles_p(g == 0 ? 256 : 4), .skip_ram_init_p(g == 2)
      ) dut (
         .clk_i(clk), .reset_i(rst[g]), .ucode_addr_o(uaddr[g]), .ucode_data_i(udata[g]),
         .io_cmd_v_o(v[g]), .io_cmd_we_o(we[g]), .io_cmd_core_o(core[g]), .io_cmd_addr_o(addr[g]),
         .io_cmd_data_o(data[g]), .io_cmd_yumi_i(yumi[g]), .io_resp_v_i(rv[g]), .io_resp_we_i(rwe[g]),
         .io_resp_data_i(rdata[g]), .io_resp_ready_o(rrdy[g]), .done_o(done[g]), .error_o(err[g]),
         .err_core_o(ecore[g]), .err_addr_o(eaddr[g])
      );
      assign udata[g] = rom(uaddr[g]);
      assign yumi[g] = v[g] & (g == 3 ? m_yumi : yen[g]);
      assign rv[g] = (g == 3) ? m_rv : p_v[g][2];
      assign rwe[g] = (g == 3) ? 1'b1 : p_we[g][2];
      assign rdata[g] = (g == 3) ? 64'h0 : p_d[g][2];
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 4; i++) begin
         p_v[i][0] <= yumi[i];
         p_we[i][0] <= we[i];
         p_d[i][0] <= we[i] ? 64'h0 : ({16'hF00D, rom(addr[i][1:0])}
                      ^ {63'b0, flip_en && i == 0 && core[i] == 2'd1 && addr[i] == 16'h8002}
                      ^ ((corrupt && i == 0) ? 64'hFF : 64'h0));
         for (int s = 1; s < 3; s++) begin
            p_v[i][s] <= p_v[i][s-1];
            p_we[i][s] <= p_we[i][s-1];
            p_d[i][s] <= p_d[i][s-1];
         end
         if (rst[i]) n[i] <= 0;
         else if (yumi[i] && n[i] < 64) begin
            lg[i][n[i]] <= '{we[i], core[i], addr[i], data[i]};
            lc[i][n[i]] <= cyc;
            n[i] <= n[i] + 1;
         end
         if (rst[i]) done_cyc[i] <= -1;
         else if (done[i] && done_cyc[i] < 0) done_cyc[i] <= cyc;
      end
   end

   task automatic cmp_vec(input int inst);
      foreach (vt[k]) if (inst < 0 || vt[k].inst == inst) begin
         cmd_t a;
         a = lg[vt[k].inst][vt[k].pos];
         chk($sformatf("cmd i%0d p%0d {we,core,addr,data}", vt[k].inst, vt[k].pos),
             {a.we, a.core, a.addr, a.data}, {vt[k].exp.we, vt[k].exp.core, vt[k].exp.addr, vt[k].exp.data});
      end
   endtask

   initial begin
      int k;
      rst = 4'hF; yen = 4'h0; flip_en = 0; corrupt = 0; m_yumi = 0; m_rv = 0;
      for (int c = 0; c < 2; c++) vt.push_back('{0, vt.size(), mk(1, c, 16'h1, 64'h1)});
      for (int c = 0; c < 2; c++) vt.push_back('{0, vt.size(), mk(1, c, 16'h2, 64'h1)});
      for (int c = 0; c < 2; c++) vt.push_back('{0, vt.size(), mk(1, c, 16'h1, 64'h0)});
      for (int c = 0; c < 2; c++) for (int x = 0; x < 4; x++)
         vt.push_back('{0, vt.size(), mk(1, c, 16'h8000 + 16'(x), {16'h0, rom(2'(x))})});
      for (int c = 0; c < 2; c++) for (int x = 0; x < 4; x++)
         vt.push_back('{0, vt.size(), mk(0, c, 16'h8000 + 16'(x), 64'h0)});
      for (int c = 0; c < 2; c++) vt.push_back('{0, vt.size(), mk(1, c, 16'h6, 64'h1)});
      for (int c = 0; c < 2; c++) vt.push_back('{0, vt.size(), mk(1, c, 16'h10, 64'h8000_0000)});
      for (int c = 0; c < 2; c++) vt.push_back('{0, vt.size(), mk(1, c, 16'h2, 64'h0)});
      for (int c = 0; c < 4; c++) vt.push_back('{1, 32 + c, mk(1, c, 16'h10, 64'h8000_0000 + 64'(c) * 64'h1000)});
      for (int c = 0; c < 2; c++) vt.push_back('{2, c, mk(1, c, 16'h2, 64'h0)});

      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("reset v%0d", i), v[i], 0);
         chk($sformatf("reset done%0d", i), done[i], 0);
         chk($sformatf("reset err%0d", i), {err[i], ecore[i], eaddr[i]}, 0);
      end
      rst = 4'h0; yen = 4'b0111; m_yumi = 1;

      for (k = 0; k < 20 && n[3] < 2; k++) @(negedge clk);
      chk("credit accepted 2", n[3], 2);
      chk("credit v drops", v[3], 0);
      repeat (3) @(negedge clk);
      chk("credit v held low", v[3], 0);
      chk("credit no accept", n[3], 2);
      m_rv = 1;
      @(negedge clk);
      chk("credit resume v", v[3], 1);
      chk("credit resume n", n[3], 2);
      @(negedge clk);
      chk("credit simul v", v[3], 1);
      chk("credit simul n", n[3], 3);
      m_rv = 0;
      @(negedge clk);
      chk("credit refill v", v[3], 0);
      chk("credit refill n", n[3], 4);
      m_yumi = 0;

      for (k = 0; k < 3000 && done[2:0] != 3'b111; k++) @(negedge clk);
      chk("main done all", done[2:0], 3'b111);
      chk("a count", n[0], 28);
      chk("c count", n[1], 40);
      chk("d count", n[2], 2);
      cmp_vec(-1);
      chk("a sync gap", (lc[0][24] - lc[0][23]) >= 256, 1);
      chk("a err", err[0], 0);
      chk("c err", err[1], 0);
      chk("d ack wait", (done_cyc[2] - lc[2][1]) >= 4, 1);
      repeat (5) @(negedge clk);
      chk("a quiet after done", {v[0], 7'(n[0])}, {1'b0, 7'd28});

      flip_en = 1; rst[0] = 1;
      repeat (2) @(negedge clk);
      rst[0] = 0;
      for (k = 0; k < 1000 && !err[0]; k++) @(negedge clk);
      repeat (20) @(negedge clk);
      chk("flip error", err[0], 1);
      chk("flip err_core", ecore[0], 1);
      chk("flip err_addr", eaddr[0], 2);
      chk("flip done", done[0], 0);
      chk("flip halt count", n[0], 22);
      chk("flip halt v", v[0], 0);

      flip_en = 0; corrupt = 1; rst[0] = 1;
      repeat (2) @(negedge clk);
      rst[0] = 0;
      for (k = 0; k < 1000 && !(v[0] && !we[0]); k++) @(negedge clk);
      chk("midrst reached verify", v[0] && !we[0], 1);
      @(negedge clk);
      rst[0] = 1; yen[0] = 0;
      @(negedge clk);
      rst[0] = 0; corrupt = 0;
      chk("midrst reset v", v[0], 0);
      chk("midrst reset err", err[0], 0);
      repeat (4) @(negedge clk);
      chk("stale ignored err", err[0], 0);
      chk("stale no accept", n[0], 0);
      chk("restart first cmd", {v[0], we[0], core[0], addr[0], data[0]}, {1'b1, 1'b1, 2'd0, 16'h1, 64'h1});
      yen[0] = 1;
      for (k = 0; k < 3000 && !done[0]; k++) @(negedge clk);
      chk("restart done", done[0], 1);
      chk("restart err", err[0], 0);
      chk("restart count", n[0], 28);
      cmp_vec(0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
